// File: rtl/waterlight_pkg.sv
// Shared definitions for the WaterLight pattern engine: pattern codes, FSM states, init patterns.
package waterlight_pkg;

  localparam logic [3:0] WL_OFF      = 4'd0;
  localparam logic [3:0] WL_SHL      = 4'd1;
  localparam logic [3:0] WL_SHR      = 4'd2;
  localparam logic [3:0] WL_FLASH    = 4'd3;
  localparam logic [3:0] WL_PINGPONG = 4'd4;

  localparam logic [7:0] WL_INIT_SHL      = 8'h01;
  localparam logic [7:0] WL_INIT_SHR      = 8'h80;
  localparam logic [7:0] WL_INIT_FLASH    = 8'hFF;
  localparam logic [7:0] WL_INIT_PINGPONG = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } wl_state_e;

  function automatic logic code_valid(input logic [3:0] code);
    return (code == WL_SHL) || (code == WL_SHR) || (code == WL_FLASH) || (code == WL_PINGPONG);
  endfunction

  function automatic logic [7:0] init_pattern(input logic [3:0] code);
    logic [7:0] p;
    case (code)
      WL_SHL:      p = WL_INIT_SHL;
      WL_SHR:      p = WL_INIT_SHR;
      WL_FLASH:    p = WL_INIT_FLASH;
      WL_PINGPONG: p = WL_INIT_PINGPONG;
      default:     p = 8'h00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/waterlight_prescaler.sv
// Step-rate prescaler: counts HCLK cycles and ticks once every speed_i cycles (0 = frozen).
module waterlight_prescaler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] speed_i,
  output logic        tick_o
);

  logic [31:0] cnt_q, cnt_d;

  // >= rather than == so lowering speed below the running count ticks on the next cycle
  always_comb begin
    tick_o = en_i && !clr_i && (speed_i != '0) && (cnt_q >= speed_i - 32'd1);
    cnt_d  = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (speed_i != '0) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/waterlight_sequencer.sv
// WaterLight LED pattern engine: mode-tracking FSM, pattern register and registered LED output.
// Optional 16-level PWM dimming from mode[7:4] when WATERLIGHT_PWM_EN is defined.
module waterlight_sequencer
  import waterlight_pkg::*;
#(
  parameter int unsigned LED_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [7:0]       WaterLight_mode,
  input  logic [31:0]      WaterLight_speed,
  input  logic             pwm_cnt_clear,
  output logic [LED_W-1:0] LED,
  output logic             step
);

  wl_state_e        state_q, state_d;
  logic [3:0]       mode_q;
  logic             mode_chg, code_ok, run_en, tick;
  logic [LED_W-1:0] pat_q, pat_d, led_q, led_d;
  logic             dir_q, dir_d;
  logic             step_q;

  assign code_ok  = code_valid(WaterLight_mode[3:0]);
  assign mode_chg = (WaterLight_mode[3:0] != mode_q);
  assign run_en   = (state_q == RUN) && !mode_chg;

  waterlight_prescaler u_prescaler (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .clr_i   (pwm_cnt_clear),
    .en_i    (run_en),
    .speed_i (WaterLight_speed),
    .tick_o  (tick)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= WaterLight_mode[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_chg) begin
      state_d = code_ok ? LOAD : IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        LOAD:    state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pattern is cleared on the same edge IDLE is entered; a mode change seen during LOAD defers the load
  always_comb begin
    pat_d = pat_q;
    dir_d = dir_q;
    if (state_d == IDLE) begin
      pat_d = '0;
    end else if ((state_q == LOAD) && !mode_chg) begin
      pat_d = LED_W'(init_pattern(mode_q));
      dir_d = 1'b1;
    end else if (tick) begin
      unique case (mode_q)
        WL_SHL:   pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        WL_SHR:   pat_d = {pat_q[0], pat_q[LED_W-1:1]};
        WL_FLASH: pat_d = ~pat_q;
        WL_PINGPONG: begin
          if (dir_q) begin
            pat_d = pat_q << 1;
            if (pat_d[LED_W-1]) dir_d = 1'b0;
          end else begin
            pat_d = pat_q >> 1;
            if (pat_d[0]) dir_d = 1'b1;
          end
        end
        default:  pat_d = '0;
      endcase
    end
  end

`ifdef WATERLIGHT_PWM_EN
  logic [3:0] pc_q, pc_d, duty;

  assign duty = WaterLight_mode[7:4];
  assign pc_d = pwm_cnt_clear ? '0 : pc_q + 4'd1;
  // Gate on the next pattern/PWM values so dimming shares the single output register stage
  assign led_d = ((duty == '0) || (pc_d < duty)) ? pat_d : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end
`else
  logic unused_brightness;

  assign unused_brightness = ^WaterLight_mode[7:4];
  assign led_d = pat_d;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pat_q  <= '0;
      dir_q  <= 1'b1;
      led_q  <= '0;
      step_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      step_q <= tick;
    end
  end

  assign LED  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_waterlight_sequencer.sv
// Self-checking bench for waterlight_sequencer: index-based pattern model plus directed scenarios.
module tb_waterlight_sequencer;

  logic        HCLK;
  logic        HRESETn;
  logic [7:0]  WaterLight_mode;
  logic [31:0] WaterLight_speed;
  logic        pwm_cnt_clear;
  logic [7:0]  LED;
  logic        step;

  int tests = 0;
  int fails = 0;

  waterlight_sequencer #(.LED_W(8)) dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .WaterLight_mode  (WaterLight_mode),
    .WaterLight_speed (WaterLight_speed),
    .pwm_cnt_clear    (pwm_cnt_clear),
    .LED              (LED),
    .step             (step)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern as a function of how many steps have been taken since LOAD
  function automatic logic [7:0] pat_of(input logic [3:0] code, input int unsigned k);
    int unsigned p;
    case (code)
      4'd1: return 8'h01 << (k % 8);
      4'd2: return 8'h80 >> (k % 8);
      4'd3: return ((k % 2) == 0) ? 8'hFF : 8'h00;
      4'd4: begin
        p = k % 14;
        return (p <= 7) ? (8'h01 << p) : (8'h01 << (14 - p));
      end
      default: return 8'h00;
    endcase
  endfunction

  // Model state: 0 = off, 1 = loading, 2 = running
  logic [3:0]  m_mode;
  logic [3:0]  m_code;
  int          m_phase;
  int unsigned m_idx;
  logic [31:0] m_cnt;
  logic [7:0]  m_pat;
  logic        m_step;
`ifdef WATERLIGHT_PWM_EN
  logic [3:0]  m_pc;
  logic [3:0]  m_d;
`endif

  initial begin
    m_mode = '0; m_phase = 0; m_idx = 0; m_cnt = '0; m_pat = '0; m_step = 1'b0;
`ifdef WATERLIGHT_PWM_EN
    m_pc = '0; m_d = '0;
`endif
    forever begin
      @(posedge HCLK or negedge HRESETn);
      if (!HRESETn) begin
        m_mode = '0; m_phase = 0; m_idx = 0; m_cnt = '0; m_pat = '0; m_step = 1'b0;
`ifdef WATERLIGHT_PWM_EN
        m_pc = '0; m_d = '0;
`endif
      end else begin
        m_code = WaterLight_mode[3:0];
        m_step = 1'b0;
`ifdef WATERLIGHT_PWM_EN
        m_pc = pwm_cnt_clear ? 4'd0 : m_pc + 4'd1;
        m_d  = WaterLight_mode[7:4];
`endif
        if (m_code != m_mode) begin
          m_mode = m_code;
          if (m_code >= 4'd1 && m_code <= 4'd4) begin
            m_phase = 1;
          end else begin
            m_phase = 0;
            m_pat   = 8'h00;
          end
          m_cnt = '0;
        end else if (m_phase == 1) begin
          m_phase = 2;
          m_idx   = 0;
          m_pat   = pat_of(m_mode, 0);
          m_cnt   = '0;
        end else if (m_phase == 2) begin
          if (pwm_cnt_clear) begin
            m_cnt = '0;
          end else if (WaterLight_speed != 0) begin
            if (m_cnt >= WaterLight_speed - 32'd1) begin
              m_cnt  = '0;
              m_idx  = m_idx + 1;
              m_pat  = pat_of(m_mode, m_idx);
              m_step = 1'b1;
            end else begin
              m_cnt = m_cnt + 32'd1;
            end
          end
        end
      end
    end
  end

  logic [7:0] exp_led;

  initial begin
    forever begin
      @(negedge HCLK);
`ifdef WATERLIGHT_PWM_EN
      exp_led = ((m_d == 4'd0) || (m_pc < m_d)) ? m_pat : 8'h00;
`else
      exp_led = m_pat;
`endif
      check("model_led", {24'b0, LED}, {24'b0, exp_led});
      check("model_step", {31'b0, step}, {31'b0, m_step});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  logic [7:0] shl_tab [9]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] pp_tab  [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  int on_cnt;

  initial begin
    HRESETn = 1'b0; WaterLight_mode = 8'h00; WaterLight_speed = 32'd0; pwm_cnt_clear = 1'b0;
    cyc(2);
    check("rst_led", {24'b0, LED}, 32'h00);
    check("rst_step", {31'b0, step}, 32'd0);
    HRESETn = 1'b1;

    // shift-left, speed 3
    WaterLight_mode = 8'h01; WaterLight_speed = 32'd3;
    cyc(2);
    check("shl_init", {24'b0, LED}, 32'h01);
    for (int k = 1; k <= 8; k++) begin
      cyc(3);
      check("shl_led", {24'b0, LED}, {24'b0, shl_tab[k]});
      check("shl_step", {31'b0, step}, 32'd1);
    end

    // ping-pong, speed 1
    WaterLight_mode = 8'h04; WaterLight_speed = 32'd1;
    cyc(2);
    check("pp_init", {24'b0, LED}, 32'h01);
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      check("pp_led", {24'b0, LED}, {24'b0, pp_tab[k]});
    end

    // flash, speed 5, then frozen, then speed 2
    WaterLight_mode = 8'h03; WaterLight_speed = 32'd5;
    cyc(2);
    check("flash_init", {24'b0, LED}, 32'hFF);
    cyc(5);
    check("flash_tog", {24'b0, LED}, 32'h00);
    check("flash_step", {31'b0, step}, 32'd1);
    cyc(2);
    WaterLight_speed = 32'd0;
    cyc(10);
    check("frozen_led", {24'b0, LED}, 32'h00);
    check("frozen_step", {31'b0, step}, 32'd0);
    WaterLight_speed = 32'd2;
    cyc(1);
    check("resume_led", {24'b0, LED}, 32'hFF);
    cyc(2);
    check("resume_led2", {24'b0, LED}, 32'h00);

    // clear in the cycle a tick was due
    WaterLight_mode = 8'h01; WaterLight_speed = 32'd4;
    cyc(2);
    check("clr_init", {24'b0, LED}, 32'h01);
    cyc(3);
    pwm_cnt_clear = 1'b1;
    cyc(1);
    pwm_cnt_clear = 1'b0;
    check("clr_nostep", {31'b0, step}, 32'd0);
    check("clr_noreload", {24'b0, LED}, 32'h01);
    cyc(3);
    check("clr_wait", {24'b0, LED}, 32'h01);
    cyc(1);
    check("clr_step", {31'b0, step}, 32'd1);
    check("clr_led", {24'b0, LED}, 32'h02);

    // invalid code -> IDLE, then shift-right
    WaterLight_mode = 8'h07;
    cyc(1);
    check("idle_led", {24'b0, LED}, 32'h00);
    cyc(3);
    check("idle_hold", {24'b0, LED}, 32'h00);
    WaterLight_mode = 8'h02;
    cyc(1);
    check("shr_load", {24'b0, LED}, 32'h00);
    cyc(1);
    check("shr_init", {24'b0, LED}, 32'h80);

    // brightness code, frozen flash
    WaterLight_mode = 8'h43; WaterLight_speed = 32'd0;
    cyc(2);
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      if (LED == 8'hFF) on_cnt++;
    end
`ifdef WATERLIGHT_PWM_EN
    check("pwm_quarter", on_cnt, 32'd4);
`else
    check("bright_ignored", on_cnt, 32'd16);
`endif
    WaterLight_mode = 8'h03;
    cyc(2);
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      if (LED == 8'hFF) on_cnt++;
    end
    check("full_on", on_cnt, 32'd16);

    // speed lowered below the running count
    WaterLight_mode = 8'h01; WaterLight_speed = 32'd10;
    cyc(2);
    check("slow_init", {24'b0, LED}, 32'h01);
    cyc(6);
    WaterLight_speed = 32'd2;
    cyc(1);
    check("speed_drop_step", {31'b0, step}, 32'd1);
    check("speed_drop_led", {24'b0, LED}, 32'h02);

    // asynchronous reset mid-run, valid mode present at release
    WaterLight_speed = 32'd1;
    cyc(5);
    HRESETn = 1'b0;
    #1;
    check("arst_led", {24'b0, LED}, 32'h00);
    check("arst_step", {31'b0, step}, 32'd0);
    WaterLight_mode = 8'h02;
    cyc(1);
    HRESETn = 1'b1;
    cyc(2);
    check("post_rst_led", {24'b0, LED}, 32'h80);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
